bzmusic_seq: RTL and testbench



---
 rtl/bzmusic_seq.sv | 203 ++++++++++++++++++++
 tb/tb_bzmusic_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bzmusic_seq.sv
// bzmusic_seq: buzzer music sequencer.
// Fetches tune/beat words from a synchronous score memory (RD_LAT cycles
// read latency), times beats from an external tick strobe and drives a
// square-wave buzzer. Supports loop playback, pause, rest notes, an in-band
// end-of-score marker and address wrap.
// Optional: define BZMUSIC_SEQ_NOTE_CNT_EN to add the note_cnt output
// (saturating count of completed beats since the last start).
module bzmusic_seq #(
    parameter int ADDR_W = 8,
    parameter int TUNE_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              loop_en,
    input  logic              pause,
    input  logic              tick,
    output logic              score_rd,
    output logic [ADDR_W-1:0] score_addr,
    input  logic [TUNE_W:0]   score_data,
    output logic              pwm_out,
    output logic              busy,
    output logic              done
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
    ,
    output logic [15:0]       note_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_PLAY} state_t;

    // Last WAIT count before DECODE; unused when RD_LAT == 1.
    localparam logic [1:0] WAIT_LAST = 2'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [TUNE_W-1:0]   tune_q, tune_d;
    logic [TUNE_W-1:0]   len_q, len_d;
    logic [TUNE_W-1:0]   bcnt_q, bcnt_d;
    logic [TUNE_W-1:0]   pcnt_q, pcnt_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic                rd_d, pwm_d, busy_d, done_d;
    logic                adv, eos;
    logic [TUNE_W-1:0]   payload;
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
    logic [15:0]         note_d;
`endif

    assign payload = score_data[TUNE_W-1:0];

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            score_addr <= '0;
            score_rd   <= 1'b0;
            pwm_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tune_q     <= '0;
            len_q      <= '0;
            bcnt_q     <= '0;
            pcnt_q     <= '0;
            wcnt_q     <= '0;
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
            note_cnt   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            score_addr <= addr_d;
            score_rd   <= rd_d;
            pwm_out    <= pwm_d;
            busy       <= busy_d;
            done       <= done_d;
            tune_q     <= tune_d;
            len_q      <= len_d;
            bcnt_q     <= bcnt_d;
            pcnt_q     <= pcnt_d;
            wcnt_q     <= wcnt_d;
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
            note_cnt   <= note_d;
`endif
        end
    end

    // Next-state, score decode, beat timing and pwm generation.
    always_comb begin
        state_d = state_q;
        addr_d  = score_addr;
        tune_d  = tune_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        pcnt_d  = pcnt_q;
        wcnt_d  = wcnt_q;
        pwm_d   = 1'b0;
        done_d  = 1'b0;
        adv     = 1'b0;
        eos     = 1'b0;
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
        note_d  = note_cnt;
`endif

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    tune_d  = '0;
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
                    note_d  = '0;
`endif
                end
            end
            S_FETCH: begin
                wcnt_d  = '0;
                state_d = (RD_LAT == 1) ? S_DECODE : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) state_d = S_DECODE;
                else                     wcnt_d  = wcnt_q + 2'd1;
            end
            S_DECODE: begin
                if (score_data[TUNE_W]) begin
                    tune_d = payload;
                    adv    = 1'b1;
                end else if (payload != '0) begin
                    len_d   = payload;
                    bcnt_d  = '0;
                    state_d = S_PLAY;
                end else begin
                    eos = 1'b1;
                end
            end
            S_PLAY: begin
                if (tick && !pause) begin
                    if (bcnt_q == len_q - 1'b1) begin
                        adv = 1'b1;
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
                        if (note_cnt != 16'hFFFF) note_d = note_cnt + 16'd1;
`endif
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Advancing past the top address counts as the end of the score.
        if (adv) begin
            if (&score_addr) begin
                eos = 1'b1;
            end else begin
                addr_d  = score_addr + 1'b1;
                state_d = S_FETCH;
            end
        end

        if (eos) begin
            addr_d = '0;
            if (loop_en) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        // Tone only while staying in PLAY, unpaused, with a non-rest tune;
        // otherwise the counter restarts from 0. Outside PLAY it is held.
        if (state_q == S_PLAY) begin
            if (state_d == S_PLAY && !pause && tune_q != '0) begin
                if (pcnt_q == tune_q - 1'b1) begin
                    pwm_d  = ~pwm_out;
                    pcnt_d = '0;
                end else begin
                    pwm_d  = pwm_out;
                    pcnt_d = pcnt_q + 1'b1;
                end
            end else begin
                pcnt_d = '0;
            end
        end

        // Stop overrides everything, including a coincident end-of-score.
        if (state_q != S_IDLE && !en) begin
            state_d = S_IDLE;
            addr_d  = '0;
            tune_d  = '0;
            len_d   = '0;
            bcnt_d  = '0;
            pcnt_d  = '0;
            wcnt_d  = '0;
            pwm_d   = 1'b0;
            done_d  = 1'b0;
        end

        rd_d   = (state_d == S_FETCH);
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_bzmusic_seq.sv
// tb_bzmusic_seq: directed bench for bzmusic_seq (ADDR_W=2, RD_LAT=2).
// Expected read addresses are queued when each run is started and compared
// in order against the reads the DUT issues; pwm half-periods, done pulses
// and busy/pwm levels are checked at the end of each run.
module tb_bzmusic_seq;
    localparam int AW = 2;
    localparam int TW = 16;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rstn, en, loop_en, pause, tick;
    logic          score_rd;
    logic [AW-1:0] score_addr;
    logic [TW:0]   score_data;
    logic          pwm_out, busy, done;
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
    logic [15:0]   note_cnt;
`endif

    always #5 clk = ~clk;

    bzmusic_seq #(.ADDR_W(AW), .TUNE_W(TW), .RD_LAT(RL)) dut (
        .clk(clk), .rstn(rstn), .en(en), .loop_en(loop_en), .pause(pause),
        .tick(tick), .score_rd(score_rd), .score_addr(score_addr),
        .score_data(score_data), .pwm_out(pwm_out), .busy(busy), .done(done)
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
        , .note_cnt(note_cnt)
`endif
    );

    // Score memory model with RL-cycle read latency.
    logic [TW:0] mem  [4];
    logic [TW:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= mem[score_addr];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign score_data = pipe[RL-1];

    // Tick generator: periodic (tick_per != 0) plus requested single ticks.
    int tick_per = 0, tcnt = 0, man_ticks = 0, man_done = 0;
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (man_done < man_ticks) begin
                tick = 1'b1; man_done++;
            end else if (tick_per != 0 && tcnt >= tick_per - 1) begin
                tick = 1'b1; tcnt = 0;
            end else begin
                tick = 1'b0;
                if (tick_per != 0) tcnt++;
            end
        end
    end

    // Monitor: logs reads, done pulses and pwm half-periods within a tone.
    int   rd_log[$];
    int   iv_log[$];
    int   done_cnt = 0, tog_cnt = 0, cyc = 0, last_tog = 0;
    bit   tog_ok = 0;
    logic pwm_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (score_rd === 1'b1) rd_log.push_back(int'(score_addr));
            if (done === 1'b1) done_cnt++;
            if (score_rd !== 1'b0 || pause || busy !== 1'b1) begin
                tog_ok = 0;
            end else if (pwm_out !== pwm_prev) begin
                tog_cnt++;
                if (tog_ok) iv_log.push_back(cyc - last_tog);
                last_tog = cyc;
                tog_ok   = 1;
            end
            pwm_prev = pwm_out;
        end
    end

    int checks = 0, errors = 0;
    int sb[$];
    int rd_idx = 0, iv_idx = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare logged reads against the scoreboard, then pwm half-periods.
    task automatic drain(input string tag, input int half);
        while (rd_idx < rd_log.size()) begin
            int a;
            a = rd_log[rd_idx];
            rd_idx++;
            if (sb.size() == 0) check({tag, "_extra_rd"}, a, -1);
            else                check({tag, "_rd_addr"}, a, sb.pop_front());
        end
        check({tag, "_rd_missing"}, sb.size(), 0);
        sb.delete();
        while (iv_idx < iv_log.size()) begin
            check({tag, "_pwm_half"}, iv_log[iv_idx], half);
            iv_idx++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for done at a falling edge and drops en before the DUT can restart.
    task automatic wait_done(input string tag, input int maxc);
        bit f;
        f = 0;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin f = 1; break; end
        end
        en = 1'b0;
        check({tag, "_done_seen"}, int'(f), 1);
    endtask

    task automatic mtick();
        man_ticks++;
        cycles(4);
    endtask

    function automatic logic [TW:0] word(input bit t, input int p);
        logic [TW-1:0] pl;
        pl = p[TW-1:0];
        return {t, pl};
    endfunction

    initial begin
        int d0, g0, base, hi;
        bit f;
        rstn = 1'b0; en = 1'b0; loop_en = 1'b0; pause = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_score_rd", int'(score_rd), 0);
        check("rst_score_addr", int'(score_addr), 0);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rstn = 1'b1;
        cycles(2);
        rd_idx = rd_log.size();

        // Run 1: tune 4, beat 3, end marker; single pass.
        mem[0] = word(1, 4); mem[1] = word(0, 3); mem[2] = word(0, 0);
        sb.push_back(0); sb.push_back(1); sb.push_back(2);
        tick_per = 20; d0 = done_cnt; g0 = tog_cnt;
        en = 1'b1;
        wait_done("t1", 600);
        cycles(5);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_busy", int'(busy), 0);
        check("t1_pwm_low", int'(pwm_out), 0);
        check("t1_toggled", int'(tog_cnt - g0 > 4), 1);
`ifdef BZMUSIC_SEQ_NOTE_CNT_EN
        check("t1_note_cnt", int'(note_cnt), 1);
`endif
        drain("t1", 4);

        // Run 2: same score looping; stop after three full passes.
        loop_en = 1'b1; tick_per = 4; d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(0); sb.push_back(1); sb.push_back(2);
        end
        base = rd_log.size();
        en = 1'b1;
        f = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            if (rd_log.size() >= base + 9) begin f = 1; break; end
        end
        #1 en = 1'b0;
        check("t2_three_loops", int'(f), 1);
        cycles(3);
        check("t2_no_done", done_cnt - d0, 0);
        check("t2_busy", int'(busy), 0);
        check("t2_pwm_low", int'(pwm_out), 0);
        drain("t2", 4);

        // Run 3: rest note.
        loop_en = 1'b0; tick_per = 10; g0 = tog_cnt;
        mem[0] = word(1, 0); mem[1] = word(0, 2); mem[2] = word(0, 0);
        sb.push_back(0); sb.push_back(1); sb.push_back(2);
        cycles(1);
        en = 1'b1;
        wait_done("t3", 300);
        cycles(3);
        check("t3_rest_no_toggle", tog_cnt - g0, 0);
        check("t3_busy", int'(busy), 0);
        drain("t3", 0);

        // Run 4: pause mid-beat while ticks keep arriving.
        tick_per = 0; d0 = done_cnt;
        mem[0] = word(1, 5); mem[1] = word(0, 4); mem[2] = word(0, 0);
        sb.push_back(0); sb.push_back(1); sb.push_back(2);
        base = rd_log.size();
        cycles(1);
        en = 1'b1;
        cycles(10);
        mtick(); mtick();
        pause = 1'b1;
        cycles(1);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) hi++;
            if (i % 10 == 5) man_ticks++;
        end
        check("t4_pause_pwm_low", hi, 0);
        check("t4_pause_hold_beat", rd_log.size() - base, 2);
        cycles(1);
        pause = 1'b0;
        cycles(3);
        mtick();
        cycles(8);
        check("t4_one_tick_short", rd_log.size() - base, 2);
        mtick();
        wait_done("t4", 60);
        cycles(2);
        check("t4_done_once", done_cnt - d0, 1);
        drain("t4", 5);

        // Run 5: four beat words, no end marker; wrap ends the score.
        tick_per = 3; d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            mem[i] = word(0, 1);
            sb.push_back(i);
        end
        cycles(1);
        en = 1'b1;
        wait_done("t5", 300);
        cycles(2);
        check("t5_done_once", done_cnt - d0, 1);
        check("t5_busy", int'(busy), 0);
        drain("t5", 0);

        // Run 6: drop en during WAIT, then during PLAY, then re-enable.
        tick_per = 0; d0 = done_cnt;
        mem[0] = word(1, 3); mem[1] = word(0, 2); mem[2] = word(0, 0);
        sb.push_back(0);
        cycles(1);
        en = 1'b1;
        cycles(2);
        en = 1'b0;
        cycles(1);
        check("t6_wait_busy", int'(busy), 0);
        check("t6_wait_rd", int'(score_rd), 0);
        drain("t6a", 3);
        sb.push_back(0); sb.push_back(1);
        en = 1'b1;
        cycles(14);
        check("t6_playing_busy", int'(busy), 1);
        en = 1'b0;
        cycles(1);
        check("t6_play_busy", int'(busy), 0);
        check("t6_play_pwm", int'(pwm_out), 0);
        cycles(3);
        check("t6_no_done", done_cnt - d0, 0);
        drain("t6b", 3);
        sb.push_back(0); sb.push_back(1); sb.push_back(2);
        tick_per = 5;
        en = 1'b1;
        wait_done("t6c", 300);
        cycles(2);
        drain("t6c", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
